// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baud-clocked UART frame serializer (start, LSB-first data, optional parity, stop); define UART_TX_HOLD_BUF_EN for a one-entry holding buffer
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  reference_clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_data_valid,
  output logic                  tx_data_ready,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n, src_data;
  logic [CW-1:0] cnt, cnt_n;
  logic par_en, par_en_n, par_bit, par_bit_n, src_en, src_bit;
  logic tx_out_n, busy_n, ready_n, acc, load;
`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hold_data, hold_data_n;
  logic hold_en, hold_en_n, hold_bit, hold_bit_n, hold_full, hold_full_n, from_hold, wr;
`endif
  always_ff @(posedge reference_clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      tx_out <= 1'b1;
      busy <= 1'b0;
      tx_data_ready <= 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
      hold_data <= '0;
      hold_en <= 1'b0;
      hold_bit <= 1'b0;
      hold_full <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt <= cnt_n;
      par_en <= par_en_n;
      par_bit <= par_bit_n;
      tx_out <= tx_out_n;
      busy <= busy_n;
      tx_data_ready <= ready_n;
`ifdef UART_TX_HOLD_BUF_EN
      hold_data <= hold_data_n;
      hold_en <= hold_en_n;
      hold_bit <= hold_bit_n;
      hold_full <= hold_full_n;
`endif
    end
  end
  always_comb begin
    acc = tx_data_valid && tx_data_ready;
`ifdef UART_TX_HOLD_BUF_EN
    from_hold = state == STOP && hold_full;
    load = from_hold || (acc && (state == IDLE || state == STOP));
    wr = acc && !(load && !from_hold);
    src_data = from_hold ? hold_data : tx_data;
    src_en = from_hold ? hold_en : parity_enable;
    src_bit = from_hold ? hold_bit : ^tx_data ^ parity_type;
    hold_full_n = wr || (hold_full && !from_hold);
    hold_data_n = wr ? tx_data : hold_data;
    hold_en_n = wr ? parity_enable : hold_en;
    hold_bit_n = wr ? ^tx_data ^ parity_type : hold_bit;
`else
    load = acc;
    src_data = tx_data;
    src_en = parity_enable;
    src_bit = ^tx_data ^ parity_type;
`endif
    state_n = (state == IDLE || state == STOP) ? (load ? START : IDLE)
            : state == START ? DATA
            : state == DATA ? (cnt == CW'(DATA_WIDTH - 1) ? (par_en ? PARITY : STOP) : DATA)
            : STOP;
    cnt_n = (state == DATA && state_n == DATA) ? cnt + CW'(1) : '0;
    shift_n = load ? src_data : state_n == DATA ? shift >> 1 : shift;
    par_en_n = load ? src_en : par_en;
    par_bit_n = load ? src_bit : par_bit;
    tx_out_n = state_n == START ? 1'b0
             : state_n == DATA ? shift[0]
             : state_n == PARITY ? par_bit
             : 1'b1;
    busy_n = state_n != IDLE;
`ifdef UART_TX_HOLD_BUF_EN
    ready_n = !hold_full_n;
`else
    ready_n = state_n == IDLE;
`endif
  end
endmodule
